fpga_cfg_master: RTL

Single-clock configuration master that sits directly upstream of the backend and replaces the behavioural FPGA model with a synthesizable stage. After board reset it holds the backend in reset and then releases it. It then shifts a configuration word into the backend's serial port on `o_sclk`/`o_sdout`, and waits for the backend's `ready` handshake. It reports completion or timeout to the host logic.

---
 rtl/fpga_cfg_if.sv | 20 ++
 rtl/fpga_cfg_master.sv | 115 +++++++++++
 2 files changed

// File: rtl/fpga_cfg_if.sv
// fpga_cfg_if: host/backend signal bundle around the configuration master
interface fpga_cfg_if #(parameter int CFG_WIDTH = 8);
  logic i_ready;
  logic [CFG_WIDTH-1:0] i_cfg_word;
  logic i_start;
  logic o_resetbAll;
  logic o_sclk;
  logic o_sdout;
  logic o_busy;
  logic o_done;
  logic o_timeout;
  modport master(
    input i_ready, i_cfg_word, i_start,
    output o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_timeout
  );
  modport slave(
    output i_ready, i_cfg_word, i_start,
    input o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_timeout
  );
endinterface

// File: rtl/fpga_cfg_master.sv
// fpga_cfg_master: backend reset hold, MSB-first serial config shift, ready/timeout handshake
module fpga_cfg_master #(
  parameter int CFG_WIDTH = 8,
  parameter int SCLK_DIV = 2,
  parameter int RST_HOLD = 4,
  parameter int READY_TIMEOUT = 64
) (
  input logic i_mainclk,
  input logic i_resetbFPGA,
  fpga_cfg_if.master bus
);
  localparam int MX0 = RST_HOLD > 2 * SCLK_DIV ? RST_HOLD : 2 * SCLK_DIV;
  localparam int MX = MX0 > READY_TIMEOUT ? MX0 : READY_TIMEOUT;
  localparam int CW = $clog2(MX + 1);
  localparam int BW = $clog2(CFG_WIDTH + 1);
  typedef enum logic [2:0] {HOLD, SHIFT, WAIT_READY, DONE, TIMEOUT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [CFG_WIDTH-1:0] shadow, shadow_n;
  logic resetb_all, sclk, sdout, busy, done, timeout;
  logic resetb_all_n, sclk_n, sdout_n, busy_n, done_n, timeout_n;
  assign bus.o_resetbAll = resetb_all;
  assign bus.o_sclk = sclk;
  assign bus.o_sdout = sdout;
  assign bus.o_busy = busy;
  assign bus.o_done = done;
  assign bus.o_timeout = timeout;
  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    bit_cnt_n = bit_cnt;
    shadow_n = shadow;
    resetb_all_n = resetb_all;
    sclk_n = sclk;
    sdout_n = sdout;
    busy_n = busy;
    done_n = done;
    timeout_n = timeout;
    case (state)
      HOLD: begin
        busy_n = 1'b1;
        if (cnt == CW'(RST_HOLD - 1)) begin
          state_n = SHIFT;
          cnt_n = '0;
          bit_cnt_n = '0;
          resetb_all_n = 1'b1;
          shadow_n = bus.i_cfg_word;
          sdout_n = bus.i_cfg_word[CFG_WIDTH-1];
          sclk_n = 1'b0;
        end
      end
      SHIFT: begin
        sclk_n = cnt == CW'(SCLK_DIV - 1) ? 1'b1 : sclk;
        if (cnt == CW'(2 * SCLK_DIV - 1)) begin
          cnt_n = '0;
          sclk_n = 1'b0;
          bit_cnt_n = bit_cnt + BW'(1);
          shadow_n = shadow << 1;
          state_n = bit_cnt == BW'(CFG_WIDTH - 1) ? WAIT_READY : SHIFT;
          sdout_n = bit_cnt == BW'(CFG_WIDTH - 1) ? 1'b0 : shadow_n[CFG_WIDTH-1];
        end
      end
      WAIT_READY: begin
        if (bus.i_ready) begin
          state_n = DONE;
          done_n = 1'b1;
          busy_n = 1'b0;
        end else if (cnt == CW'(READY_TIMEOUT - 1)) begin
          state_n = TIMEOUT;
          timeout_n = 1'b1;
          busy_n = 1'b0;
          resetb_all_n = 1'b0;
        end
      end
      DONE, TIMEOUT: begin
        cnt_n = cnt;
        if (bus.i_start) begin
          state_n = HOLD;
          cnt_n = '0;
          resetb_all_n = 1'b0;
          done_n = 1'b0;
          timeout_n = 1'b0;
          busy_n = 1'b1;
        end
      end
      default: state_n = HOLD;
    endcase
  end
  always_ff @(posedge i_mainclk) begin
    if (!i_resetbFPGA) begin
      state <= HOLD;
      cnt <= '0;
      bit_cnt <= '0;
      shadow <= '0;
      resetb_all <= 1'b0;
      sclk <= 1'b0;
      sdout <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_cnt_n;
      shadow <= shadow_n;
      resetb_all <= resetb_all_n;
      sclk <= sclk_n;
      sdout <= sdout_n;
      busy <= busy_n;
      done <= done_n;
      timeout <= timeout_n;
    end
  end
endmodule
